// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path.
// Contents: opcode values, FSM state encodings, ALU operand/op selects,
// trap cause codes and the packed control-word struct driven by the FSM.
package riscv_ctrl_pkg;

   // Major opcodes (instr[6:0])
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // FSM state encodings; visible on state_out_o, so values are fixed
   localparam logic [3:0] ST_RESET     = 4'd0;
   localparam logic [3:0] ST_FETCH     = 4'd1;
   localparam logic [3:0] ST_DECODE    = 4'd2;
   localparam logic [3:0] ST_MEM_ADDR  = 4'd3;
   localparam logic [3:0] ST_MEM_READ  = 4'd4;
   localparam logic [3:0] ST_MEM_WB    = 4'd5;
   localparam logic [3:0] ST_MEM_WRITE = 4'd6;
   localparam logic [3:0] ST_EXEC_R    = 4'd7;
   localparam logic [3:0] ST_EXEC_I    = 4'd8;
   localparam logic [3:0] ST_ALU_WB    = 4'd9;
   localparam logic [3:0] ST_BRANCH    = 4'd10;
   localparam logic [3:0] ST_TRAP      = 4'd15;

   // ALU operand A select
   localparam logic [1:0] ALU_A_PC    = 2'b00;
   localparam logic [1:0] ALU_A_RS1   = 2'b01;
   localparam logic [1:0] ALU_A_OLDPC = 2'b10;

   // ALU operand B select
   localparam logic [1:0] ALU_B_RS2  = 2'b00;
   localparam logic [1:0] ALU_B_FOUR = 2'b01;
   localparam logic [1:0] ALU_B_IMM  = 2'b10;

   // ALU operation
   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   // Trap causes
   localparam logic [1:0] CAUSE_NONE        = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL     = 2'b01;
   localparam logic [1:0] CAUSE_MEM_TIMEOUT = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       ir_write;
      logic       i_or_d;
      logic       mem_req;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_retired;
   } ctrl_t;

   // States in which the FSM holds a memory request open
   function automatic logic is_mem_state(logic [3:0] st);
      return (st == ST_FETCH) || (st == ST_MEM_READ) || (st == ST_MEM_WRITE);
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter and timeout comparator.
// Counts cycles in which a request is outstanding without ready; clears on
// every FSM state change. timeout_o flags the last permitted wait cycle so the
// FSM can divert to TRAP instead of waiting another cycle.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   clear_i        FSM state is changing this cycle
//   busy_i         mem_req high and mem_ready low this cycle
//   timeout_o      wait limit reached while still busy
module mem_wait_timer #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned WAIT_CNT_W   = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic busy_i,
   output logic timeout_o
);

   localparam int unsigned LimitInt = (MEM_WAIT_MAX == 0) ? 0 : MEM_WAIT_MAX - 1;
   localparam logic [WAIT_CNT_W-1:0] Limit = WAIT_CNT_W'(LimitInt);

   logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (clear_i) begin
         wait_cnt_d = '0;
      end else if (busy_i) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wait_cnt_q <= '0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
      end
   end

   // A ready arriving on the limit cycle deasserts busy_i, so it wins
   assign timeout_o = (MEM_WAIT_MAX != 0) && busy_i && (wait_cnt_q == Limit);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32I core.
// Sequences each instruction over 3-5 cycles through a shared ALU and a
// unified memory with a req/ready handshake. Illegal opcodes and memory wait
// timeouts enter a sticky TRAP state held until reset.
// Optional feature: define MULTICYCLE_PERF_CNT_EN to add cycle_count_o and
// retired_count_o performance counters.
// Ports:
//   clk_i, rst_ni       clock, async active-low reset
//   opcode_i            instr[6:0] from the instruction register
//   zero_i              ALU zero flag (branch resolved in the datapath)
//   mem_ready_i         memory completes the current access
//   pc_write_o ... alu_op_o   datapath control word
//   instr_retired_o     one-cycle completion pulse
//   trap_o, trap_cause_o  sticky trap flag and latched cause
//   state_out_o         current state, for debug
module multicycle_control #(
   parameter int unsigned MEM_WAIT_MAX = 15,
   parameter int unsigned WAIT_CNT_W   = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [6:0]       opcode_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             pc_write_cond_o,
   output logic             pc_source_o,
   output logic             ir_write_o,
   output logic             i_or_d_o,
   output logic             mem_req_o,
   output logic             mem_write_o,
   output logic             mem_to_reg_o,
   output logic             reg_write_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       alu_op_o,
   output logic             instr_retired_o,
   output logic             trap_o,
   output logic [1:0]       trap_cause_o,
   output logic [3:0]       state_out_o
`ifdef MULTICYCLE_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_count_o,
   output logic [CNT_W-1:0] retired_count_o
`endif
);

   import riscv_ctrl_pkg::*;

   logic [3:0] state_q, state_d;
   logic [1:0] trap_cause_q, trap_cause_d;
   logic [1:0] entry_cause;
   ctrl_t      ctrl;
   logic       mem_req;
   logic       timeout;

   // Branch outcome is applied by the datapath through pc_write_cond
   logic unused_zero;
   assign unused_zero = zero_i;

   // Kept separate from the main decode so the timer input has no path
   // through the next-state logic it feeds
   assign mem_req = is_mem_state(state_q);

   mem_wait_timer #(
      .MEM_WAIT_MAX(MEM_WAIT_MAX),
      .WAIT_CNT_W  (WAIT_CNT_W)
   ) u_mem_wait_timer (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (state_d != state_q),
      .busy_i   (mem_req & ~mem_ready_i),
      .timeout_o(timeout)
   );

   always_comb begin
      ctrl        = '0;
      state_d     = state_q;
      entry_cause = CAUSE_NONE;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.alu_src_a = ALU_A_PC;
            ctrl.alu_src_b = ALU_B_FOUR;
            ctrl.alu_op    = ALU_OP_ADD;
            if (mem_ready_i) begin
               ctrl.ir_write = 1'b1;
               ctrl.pc_write = 1'b1;
               state_d       = ST_DECODE;
            end else if (timeout) begin
               state_d     = ST_TRAP;
               entry_cause = CAUSE_MEM_TIMEOUT;
            end
         end
         ST_DECODE: begin
            // Speculative branch target into ALUOut
            ctrl.alu_src_a = ALU_A_OLDPC;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
            case (opcode_i)
               OP_R:               state_d = ST_EXEC_R;
               OP_I:               state_d = ST_EXEC_I;
               OP_LOAD, OP_STORE:  state_d = ST_MEM_ADDR;
               OP_BRANCH:          state_d = ST_BRANCH;
               default: begin
                  state_d     = ST_TRAP;
                  entry_cause = CAUSE_ILLEGAL;
               end
            endcase
         end
         ST_MEM_ADDR: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_ADD;
            state_d        = (opcode_i == OP_STORE) ? ST_MEM_WRITE : ST_MEM_READ;
         end
         ST_MEM_READ: begin
            ctrl.mem_req = 1'b1;
            ctrl.i_or_d  = 1'b1;
            if (mem_ready_i) begin
               state_d = ST_MEM_WB;
            end else if (timeout) begin
               state_d     = ST_TRAP;
               entry_cause = CAUSE_MEM_TIMEOUT;
            end
         end
         ST_MEM_WB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.mem_to_reg    = 1'b1;
            ctrl.instr_retired = 1'b1;
            state_d            = ST_FETCH;
         end
         ST_MEM_WRITE: begin
            ctrl.mem_req   = 1'b1;
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
            if (mem_ready_i) begin
               ctrl.instr_retired = 1'b1;
               state_d            = ST_FETCH;
            end else if (timeout) begin
               state_d     = ST_TRAP;
               entry_cause = CAUSE_MEM_TIMEOUT;
            end
         end
         ST_EXEC_R: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_RS2;
            ctrl.alu_op    = ALU_OP_FUNCT;
            state_d        = ST_ALU_WB;
         end
         ST_EXEC_I: begin
            ctrl.alu_src_a = ALU_A_RS1;
            ctrl.alu_src_b = ALU_B_IMM;
            ctrl.alu_op    = ALU_OP_FUNCT;
            state_d        = ST_ALU_WB;
         end
         ST_ALU_WB: begin
            ctrl.reg_write     = 1'b1;
            ctrl.instr_retired = 1'b1;
            state_d            = ST_FETCH;
         end
         ST_BRANCH: begin
            ctrl.alu_src_a     = ALU_A_RS1;
            ctrl.alu_src_b     = ALU_B_RS2;
            ctrl.alu_op        = ALU_OP_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 1'b1;
            ctrl.instr_retired = 1'b1;
            state_d            = ST_FETCH;
         end
         ST_TRAP: state_d = ST_TRAP;
         // Unused encodings restart the sequencer
         default: state_d = ST_RESET;
      endcase
   end

   // Cause is captured only on the entry transition, never overwritten
   always_comb begin
      trap_cause_d = trap_cause_q;
      if ((state_q != ST_TRAP) && (state_d == ST_TRAP)) begin
         trap_cause_d = entry_cause;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_RESET;
         trap_cause_q <= CAUSE_NONE;
      end else begin
         state_q      <= state_d;
         trap_cause_q <= trap_cause_d;
      end
   end

   assign pc_write_o      = ctrl.pc_write;
   assign pc_write_cond_o = ctrl.pc_write_cond;
   assign pc_source_o     = ctrl.pc_source;
   assign ir_write_o      = ctrl.ir_write;
   assign i_or_d_o        = ctrl.i_or_d;
   assign mem_req_o       = ctrl.mem_req;
   assign mem_write_o     = ctrl.mem_write;
   assign mem_to_reg_o    = ctrl.mem_to_reg;
   assign reg_write_o     = ctrl.reg_write;
   assign alu_src_a_o     = ctrl.alu_src_a;
   assign alu_src_b_o     = ctrl.alu_src_b;
   assign alu_op_o        = ctrl.alu_op;
   assign instr_retired_o = ctrl.instr_retired;
   assign trap_o          = (state_q == ST_TRAP);
   assign trap_cause_o    = trap_cause_q;
   assign state_out_o     = state_q;

`ifdef MULTICYCLE_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
   logic [CNT_W-1:0] retired_count_q, retired_count_d;

   always_comb begin
      cycle_count_d   = cycle_count_q;
      retired_count_d = retired_count_q;
      if ((state_q != ST_RESET) && (state_q != ST_TRAP)) begin
         cycle_count_d = cycle_count_q + 1'b1;
      end
      if (ctrl.instr_retired) begin
         retired_count_d = retired_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_count_q   <= '0;
         retired_count_q <= '0;
      end else begin
         cycle_count_q   <= cycle_count_d;
         retired_count_q <= retired_count_d;
      end
   end

   assign cycle_count_o   = cycle_count_q;
   assign retired_count_o = retired_count_q;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control.
// Each instruction is expanded into a planned per-cycle trace (state number,
// mem_ready value) from the instruction class and chosen memory latencies; the
// expected control word for each planned cycle comes from the per-state
// output table. Directed scenarios run first, then random instructions.
module tb_multicycle_control;

   localparam int TIMEOUT = 15;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [6:0]  opcode_i;
   logic        zero_i;
   logic        mem_ready_i;
   logic        pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, i_or_d_o;
   logic        mem_req_o, mem_write_o, mem_to_reg_o, reg_write_o;
   logic [1:0]  alu_src_a_o, alu_src_b_o, alu_op_o;
   logic        instr_retired_o, trap_o;
   logic [1:0]  trap_cause_o;
   logic [3:0]  state_out_o;
`ifdef MULTICYCLE_PERF_CNT_EN
   logic [31:0] cycle_count_o, retired_count_o;
`endif

   multicycle_control #(
      .MEM_WAIT_MAX(15),
      .WAIT_CNT_W  (4),
      .CNT_W       (32)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .opcode_i       (opcode_i),
      .zero_i         (zero_i),
      .mem_ready_i    (mem_ready_i),
      .pc_write_o     (pc_write_o),
      .pc_write_cond_o(pc_write_cond_o),
      .pc_source_o    (pc_source_o),
      .ir_write_o     (ir_write_o),
      .i_or_d_o       (i_or_d_o),
      .mem_req_o      (mem_req_o),
      .mem_write_o    (mem_write_o),
      .mem_to_reg_o   (mem_to_reg_o),
      .reg_write_o    (reg_write_o),
      .alu_src_a_o    (alu_src_a_o),
      .alu_src_b_o    (alu_src_b_o),
      .alu_op_o       (alu_op_o),
      .instr_retired_o(instr_retired_o),
      .trap_o         (trap_o),
      .trap_cause_o   (trap_cause_o),
      .state_out_o    (state_out_o)
`ifdef MULTICYCLE_PERF_CNT_EN
      ,
      .cycle_count_o  (cycle_count_o),
      .retired_count_o(retired_count_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_exp = 0;
   int ret_exp = 0;
   bit zero_val = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [18:0] observed();
      return {pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, i_or_d_o, mem_req_o,
              mem_write_o, mem_to_reg_o, reg_write_o, alu_src_a_o, alu_src_b_o, alu_op_o,
              instr_retired_o, trap_o, trap_cause_o};
   endfunction

   // Per-state output table: state number, this cycle's mem_ready, latched cause
   function automatic logic [18:0] expected(input int st, input bit rdy, input logic [1:0] cause);
      logic pw = 0, pwc = 0, psrc = 0, irw = 0, iod = 0, req = 0, wr = 0, m2r = 0, rw = 0;
      logic ret = 0, tr = 0;
      logic [1:0] a = 0, b = 0, op = 0, c = 0;
      case (st)
         1:  begin req = 1; b = 2'b01; pw = rdy; irw = rdy; end
         2:  begin a = 2'b10; b = 2'b10; end
         3:  begin a = 2'b01; b = 2'b10; end
         4:  begin req = 1; iod = 1; end
         5:  begin rw = 1; m2r = 1; ret = 1; end
         6:  begin req = 1; wr = 1; iod = 1; ret = rdy; end
         7:  begin a = 2'b01; op = 2'b10; end
         8:  begin a = 2'b01; b = 2'b10; op = 2'b10; end
         9:  begin rw = 1; ret = 1; end
         10: begin a = 2'b01; op = 2'b01; pwc = 1; psrc = 1; ret = 1; end
         15: begin tr = 1; c = cause; end
         default: ;
      endcase
      return {pw, pwc, psrc, irw, iod, req, wr, m2r, rw, a, b, op, ret, tr, c};
   endfunction

   // One planned cycle; entered and left at posedge+1
   task automatic step(input int st, input bit rdy, input logic [1:0] cause, input string tag);
      logic [18:0] e;
      mem_ready_i = rdy;
      zero_i      = zero_val;
      #1;
      e = expected(st, rdy, cause);
      check({tag, "/state"}, 32'(state_out_o), 32'(st));
      check({tag, "/ctrl"}, 32'(observed()), 32'(e));
      if (st != 0 && st != 15) cyc_exp++;
      if (e[3]) ret_exp++;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_counters(input string tag);
`ifdef MULTICYCLE_PERF_CNT_EN
      check({tag, "/cycles"}, cycle_count_o, 32'(cyc_exp));
      check({tag, "/retired"}, retired_count_o, 32'(ret_exp));
`else
      check({tag, "/trap_idle"}, 32'(trap_o), 32'(state_out_o == 4'd15));
`endif
   endtask

   // Memory phase: lat cycles without ready then one with ready, unless the
   // wait reaches the timeout budget
   task automatic mem_phase(input int st, input int lat, input string tag, output bit trapped);
      trapped = 0;
      if (lat >= TIMEOUT) begin
         for (int i = 0; i < TIMEOUT; i++) step(st, 1'b0, 2'b00, tag);
         trapped = 1;
      end else begin
         for (int i = 0; i < lat; i++) step(st, 1'b0, 2'b00, tag);
         step(st, 1'b1, 2'b00, tag);
      end
   endtask

   task automatic do_reset(input string tag);
      rst_ni = 1'b0;
      #1;
      check({tag, "/rst_state"}, 32'(state_out_o), 32'd0);
      check({tag, "/rst_ctrl"}, 32'(observed()), 32'd0);
      cyc_exp = 0;
      ret_exp = 0;
      check_counters({tag, "/rst"});
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      step(0, 1'(($urandom)), 2'b00, {tag, "/reset"});
   endtask

   task automatic trap_hold(input logic [1:0] cause, input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         opcode_i = 7'($urandom);
         step(15, 1'($urandom), cause, tag);
      end
      check_counters({tag, "/trap"});
      do_reset(tag);
   endtask

   task automatic run_instr(input logic [6:0] op, input int lat_f, input int lat_m,
                            input string tag);
      bit trapped;
      opcode_i = op;
      mem_phase(1, lat_f, {tag, "/fetch"}, trapped);
      if (trapped) begin
         trap_hold(2'b10, 5, {tag, "/fetch_to"});
         return;
      end
      step(2, 1'($urandom), 2'b00, {tag, "/decode"});
      case (op)
         7'b0110011: begin step(7, 1'($urandom), 0, tag); step(9, 1'($urandom), 0, tag); end
         7'b0010011: begin step(8, 1'($urandom), 0, tag); step(9, 1'($urandom), 0, tag); end
         7'b0000011: begin
            step(3, 1'($urandom), 0, tag);
            mem_phase(4, lat_m, {tag, "/read"}, trapped);
            if (trapped) begin
               trap_hold(2'b10, 5, {tag, "/read_to"});
               return;
            end
            step(5, 1'($urandom), 0, tag);
         end
         7'b0100011: begin
            step(3, 1'($urandom), 0, tag);
            mem_phase(6, lat_m, {tag, "/write"}, trapped);
            if (trapped) begin
               trap_hold(2'b10, 5, {tag, "/write_to"});
               return;
            end
         end
         7'b1100011: step(10, 1'($urandom), 0, tag);
         default: begin
            trap_hold(2'b01, 20, {tag, "/illegal"});
            return;
         end
      endcase
      check_counters(tag);
   endtask

   function automatic int rand_lat();
      int r = int'($urandom_range(0, 19));
      if (r < 14) return int'($urandom_range(0, 3));
      if (r < 17) return TIMEOUT - 1;
      return TIMEOUT + int'($urandom_range(0, 3));
   endfunction

   initial begin
      logic [6:0] ops [5];
      logic [6:0] op;
      ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
      ops[3] = 7'b0100011; ops[4] = 7'b1100011;
      rst_ni      = 1'b0;
      opcode_i    = '0;
      zero_i      = 1'b0;
      mem_ready_i = 1'b0;
      #12;
      do_reset("init");

      // Directed scenarios
      run_instr(7'b0110011, 0, 0, "rtype");
      run_instr(7'b0000011, 0, 3, "lw_lat3");
      zero_val = 1'b1;
      run_instr(7'b1100011, 0, 0, "beq_z1");
      zero_val = 1'b0;
      run_instr(7'b1100011, 0, 0, "beq_z0");
      run_instr(7'b1111111, 0, 0, "illegal");
      run_instr(7'b0110011, TIMEOUT, 0, "fetch_timeout");
      run_instr(7'b0010011, TIMEOUT - 1, 0, "fetch_lastcycle");
      run_instr(7'b0100011, 2, TIMEOUT - 1, "sw_lastcycle");

      // Asynchronous reset in the middle of a store access
      begin
         bit tr;
         opcode_i = 7'b0100011;
         mem_phase(1, 0, "midrst/fetch", tr);
         step(2, 1'b0, 0, "midrst/decode");
         step(3, 1'b0, 0, "midrst/addr");
         mem_ready_i = 1'b0;
         #1;
         check("midrst/req_before", 32'(mem_req_o), 32'd1);
         check("midrst/wr_before", 32'(mem_write_o), 32'd1);
         rst_ni = 1'b0;
         #1;
         check("midrst/req_after", 32'(mem_req_o), 32'd0);
         check("midrst/wr_after", 32'(mem_write_o), 32'd0);
         do_reset("midrst");
      end

      // Random instruction stream
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            do begin
               op = 7'($urandom);
            end while (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011});
         end else begin
            op = ops[$urandom_range(0, 4)];
         end
         zero_val = 1'($urandom);
         run_instr(op, rand_lat(), rand_lat(), $sformatf("rnd%0d", n));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
